// File: rtl/output_drain_scheduler_if.sv
// Handshake bundle between the datapath result port, the output drain
// scheduler and the external drain consumer.
interface output_drain_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [31:0]           in_x;
  logic [31:0]           in_y;
  logic [31:0]           in_ch;
  logic                  stall;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [31:0]           out_x;
  logic [31:0]           out_y;
  logic [31:0]           out_ch;
  logic [CW-1:0]         count;
  logic                  overflow;

  // The surrounding controller and drain consumer.
  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  stall, out_valid, out_data, out_x, out_y, out_ch, count, overflow
  );

  // The scheduler itself.
  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output stall, out_valid, out_data, out_x, out_y, out_ch, count, overflow
  );
endinterface

// File: rtl/output_drain_scheduler.sv
// Circular FIFO that buffers datapath results with coordinates and drains them in order.
// Optional same-cycle bypass when empty is enabled by defining OUT_DRAIN_BYPASS_EN.
module output_drain_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    arst_in,
  output_drain_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           x;
    logic [31:0]           y;
    logic [31:0]           ch;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_state_t;

  occ_state_t    state;
  occ_state_t    state_next;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        in_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          overflow;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic          store;
  logic          advance;
  logic          bypass;

  assign in_entry = '{data: bus.in_data, x: bus.in_x, y: bus.in_y, ch: bus.in_ch};

`ifdef OUT_DRAIN_BYPASS_EN
  assign bypass = (state == EMPTY) && bus.in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never touches storage or pointers.
  always_comb begin
    out_valid = (state != EMPTY) || bypass;
    head      = bypass ? in_entry : mem[rd_ptr];
    pop       = out_valid && bus.out_ready;
    push      = bus.in_valid && ((state != FULL) || pop);
    store     = push && !(bypass && bus.out_ready);
    advance   = pop && !bypass;
    count_next = count;
    if (store && !advance) begin
      count_next = count + CW'(1);
    end else if (!store && advance) begin
      count_next = count - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (count_next == '0) begin
      state_next = EMPTY;
    end else if (count_next == CW'(DEPTH)) begin
      state_next = FULL;
    end else begin
      state_next = PARTIAL;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (advance) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (bus.in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are hidden behind out_valid.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = head.data;
  assign bus.out_x     = head.x;
  assign bus.out_y     = head.y;
  assign bus.out_ch    = head.ch;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.stall     = (count >= CW'(DEPTH - 1));

endmodule
